// File: rtl/mem_bus_arbiter.sv
// Arbitrates the IF fetch port and the MEM data port onto one Wishbone-classic master.
// Data requests win ties; results return through per-port hold registers.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_ce_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_stallreq_o,
   input  logic        dm_ce_i,
   input  logic        dm_we_i,
   input  logic [3:0]  dm_sel_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_i,
   output logic [31:0] dm_data_o,
   output logic        dm_stallreq_o,
   output logic        bus_cyc_o,
   output logic        bus_stb_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_adr_o,
   output logic [31:0] bus_dat_o,
   input  logic [31:0] bus_dat_i,
   input  logic        bus_ack_i,
   output logic        bus_timeout_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BUS_D,
      S_BUS_I,
      S_DONE_D,
      S_DONE_I
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic        r_discard;
   logic [7:0]  r_cnt;
   logic        r_cyc;
   logic        r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic [31:0] r_if_hold;
   logic [31:0] r_dm_hold;
   logic        r_timeout;

   logic        w_in_bus;
   logic        w_ack;
   logic        w_expire;
   logic        w_finish;
   logic        w_drop;
   logic        w_grant_d;
   logic        w_grant_i;
   logic [31:0] w_capture;

   assign w_in_bus  = (r_state == S_BUS_D) || (r_state == S_BUS_I);
   assign w_ack     = w_in_bus && bus_ack_i;
   // An ack on the last allowed cycle still counts as a normal completion.
   assign w_expire  = w_in_bus && !bus_ack_i && (r_cnt == CNT_LAST);
   assign w_finish  = w_ack || w_expire;
   // A flush on the completing cycle itself also discards the result.
   assign w_drop    = r_discard || flush;
   assign w_grant_d = (r_state == S_IDLE) && !flush && dm_ce_i;
   assign w_grant_i = (r_state == S_IDLE) && !flush && !dm_ce_i && if_ce_i;
   assign w_capture = (w_ack && !r_we) ? bus_dat_i : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_d) begin
               w_state_next = S_BUS_D;
            end else if (w_grant_i) begin
               w_state_next = S_BUS_I;
            end
         end
         S_BUS_D: begin
            if (w_finish) begin
               w_state_next = w_drop ? S_IDLE : S_DONE_D;
            end
         end
         S_BUS_I: begin
            if (w_finish) begin
               w_state_next = w_drop ? S_IDLE : S_DONE_I;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // A port not currently owning the bus simply mirrors its own request.
   always_comb begin
      dm_stallreq_o = dm_ce_i;
      if_stallreq_o = if_ce_i;
      case (r_state)
         S_BUS_D:  if (!r_discard) dm_stallreq_o = 1'b1;
         S_BUS_I:  if (!r_discard) if_stallreq_o = 1'b1;
         S_DONE_D: dm_stallreq_o = 1'b0;
         S_DONE_I: if_stallreq_o = 1'b0;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_discard <= 1'b0;
         r_cnt     <= 8'd0;
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_sel     <= 4'h0;
         r_adr     <= 32'h0;
         r_dat     <= 32'h0;
         r_if_hold <= 32'h0;
         r_dm_hold <= 32'h0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (w_grant_d) begin
            r_cyc <= 1'b1;
            r_we  <= dm_we_i;
            r_sel <= dm_sel_i;
            r_adr <= dm_addr_i;
            r_dat <= dm_data_i;
            r_cnt <= 8'd0;
         end else if (w_grant_i) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b0;
            r_sel <= 4'hF;
            r_adr <= if_addr_i;
            r_dat <= 32'h0;
            r_cnt <= 8'd0;
         end else if (w_finish) begin
            r_cyc <= 1'b0;
         end
         if (w_in_bus) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_finish) begin
               r_discard <= 1'b0;
            end else if (flush) begin
               r_discard <= 1'b1;
            end
         end
         if (w_finish && !w_drop) begin
            if (r_state == S_BUS_D) begin
               r_dm_hold <= w_capture;
            end else begin
               r_if_hold <= w_capture;
            end
         end
      end
   end

   assign bus_cyc_o     = r_cyc;
   assign bus_stb_o     = r_cyc;
   assign bus_we_o      = r_we;
   assign bus_sel_o     = r_sel;
   assign bus_adr_o     = r_adr;
   assign bus_dat_o     = r_dat;
   assign bus_timeout_o = r_timeout;
   assign if_data_o     = r_if_hold;
   assign dm_data_o     = r_dm_hold;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (default timeout and a 4-cycle timeout) share stimulus
// and are checked every cycle against a transaction-level model plus directed literal checks.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        if_ce;
   logic [31:0] if_addr;
   logic        dm_ce;
   logic        dm_we;
   logic [3:0]  dm_sel;
   logic [31:0] dm_addr;
   logic [31:0] dm_data;
   logic [31:0] bus_dat_i;
   logic        bus_ack;

   logic        cyc[2];
   logic        stb[2];
   logic        we[2];
   logic [3:0]  sel[2];
   logic [31:0] adr[2];
   logic [31:0] dato[2];
   logic [31:0] ifd[2];
   logic [31:0] dmd[2];
   logic        ifst[2];
   logic        dmst[2];
   logic        to[2];

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(255)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(ifd[0]), .if_stallreq_o(ifst[0]),
      .dm_ce_i(dm_ce), .dm_we_i(dm_we), .dm_sel_i(dm_sel), .dm_addr_i(dm_addr),
      .dm_data_i(dm_data), .dm_data_o(dmd[0]), .dm_stallreq_o(dmst[0]),
      .bus_cyc_o(cyc[0]), .bus_stb_o(stb[0]), .bus_we_o(we[0]), .bus_sel_o(sel[0]),
      .bus_adr_o(adr[0]), .bus_dat_o(dato[0]), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack),
      .bus_timeout_o(to[0])
   );

   mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush),
      .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(ifd[1]), .if_stallreq_o(ifst[1]),
      .dm_ce_i(dm_ce), .dm_we_i(dm_we), .dm_sel_i(dm_sel), .dm_addr_i(dm_addr),
      .dm_data_i(dm_data), .dm_data_o(dmd[1]), .dm_stallreq_o(dmst[1]),
      .bus_cyc_o(cyc[1]), .bus_stb_o(stb[1]), .bus_we_o(we[1]), .bus_sel_o(sel[1]),
      .bus_adr_o(adr[1]), .bus_dat_o(dato[1]), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack),
      .bus_timeout_o(to[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   function automatic int to_of(input int d);
      return (d == 0) ? 255 : 4;
   endfunction

   // Model: owner 0 = bus free, 1 = data, 2 = fetch; done = port enjoying its result cycle.
   int          m_owner[2];
   int          m_age[2];
   int          m_done[2];
   bit          m_drop[2];
   bit          m_to[2];
   bit          m_we[2];
   logic [3:0]  m_sel[2];
   logic [31:0] m_adr[2];
   logic [31:0] m_dat[2];
   logic [31:0] m_ifh[2];
   logic [31:0] m_dmh[2];
   logic [31:0] m_v;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_owner[d] = 0; m_age[d] = 0; m_done[d] = 0; m_drop[d] = 0; m_to[d] = 0;
            m_we[d] = 0; m_sel[d] = 4'h0; m_adr[d] = 32'h0; m_dat[d] = 32'h0;
            m_ifh[d] = 32'h0; m_dmh[d] = 32'h0;
         end else begin
            m_to[d] = 1'b0;
            if (m_owner[d] != 0) begin
               if (bus_ack || m_age[d] == to_of(d) - 1) begin
                  m_v = (bus_ack && !m_we[d]) ? bus_dat_i : 32'h0;
                  if (!(m_drop[d] || flush)) begin
                     if (m_owner[d] == 1) m_dmh[d] = m_v;
                     else m_ifh[d] = m_v;
                     m_done[d] = m_owner[d];
                  end
                  m_to[d] = !bus_ack;
                  m_owner[d] = 0;
                  m_drop[d] = 1'b0;
               end else begin
                  m_age[d]++;
                  if (flush) m_drop[d] = 1'b1;
               end
            end else if (m_done[d] != 0) begin
               m_done[d] = 0;
            end else if (!flush && (dm_ce || if_ce)) begin
               m_age[d] = 0;
               if (dm_ce) begin
                  m_owner[d] = 1; m_we[d] = dm_we; m_sel[d] = dm_sel;
                  m_adr[d] = dm_addr; m_dat[d] = dm_data;
               end else begin
                  m_owner[d] = 2; m_we[d] = 1'b0; m_sel[d] = 4'hF;
                  m_adr[d] = if_addr; m_dat[d] = 32'h0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_cyc", d), 32'(cyc[d]), 32'(m_owner[d] != 0));
            chk($sformatf("d%0d_stb", d), 32'(stb[d]), 32'(m_owner[d] != 0));
            chk($sformatf("d%0d_we", d), 32'(we[d]), 32'(m_we[d]));
            chk($sformatf("d%0d_sel", d), 32'(sel[d]), 32'(m_sel[d]));
            chk($sformatf("d%0d_adr", d), adr[d], m_adr[d]);
            chk($sformatf("d%0d_dat_o", d), dato[d], m_dat[d]);
            chk($sformatf("d%0d_if_data", d), ifd[d], m_ifh[d]);
            chk($sformatf("d%0d_dm_data", d), dmd[d], m_dmh[d]);
            chk($sformatf("d%0d_timeout", d), 32'(to[d]), 32'(m_to[d]));
            chk($sformatf("d%0d_dm_stall", d), 32'(dmst[d]),
                32'((m_owner[d] == 1 && !m_drop[d]) ? 1'b1 : (m_done[d] == 1) ? 1'b0 : dm_ce));
            chk($sformatf("d%0d_if_stall", d), 32'(ifst[d]),
                32'((m_owner[d] == 2 && !m_drop[d]) ? 1'b1 : (m_done[d] == 2) ? 1'b0 : if_ce));
         end
      end
   end

   task automatic clear_inputs;
      flush = 0; if_ce = 0; if_addr = 0; dm_ce = 0; dm_we = 0; dm_sel = 0;
      dm_addr = 0; dm_data = 0; bus_dat_i = 0; bus_ack = 0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      clear_inputs();
      next_cycle();
      rst = 1'b0;
   endtask

   int stall_cnt;

   initial begin
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_on = 1'b1;
      @(negedge clk);
      chk("reset_cyc", 32'(cyc[0]), 32'd0);
      chk("reset_adr", adr[0], 32'h0);
      chk("reset_dm_data", dmd[0], 32'h0);
      next_cycle();

      // Single load
      do_reset();
      dm_ce = 1; dm_addr = 32'h100; dm_sel = 4'hF;
      @(negedge clk);
      chk("load_stall_c0", 32'(dmst[0]), 32'd1);
      next_cycle();
      bus_ack = 1; bus_dat_i = 32'hDEADBEEF;
      @(negedge clk);
      chk("load_stall_c1", 32'(dmst[0]), 32'd1);
      chk("load_adr", adr[0], 32'h100);
      next_cycle();
      bus_ack = 0;
      @(negedge clk);
      chk("load_stall_c2", 32'(dmst[0]), 32'd0);
      chk("load_data", dmd[0], 32'hDEADBEEF);
      next_cycle();
      dm_ce = 0;
      @(negedge clk);
      next_cycle();

      // Simultaneous store and fetch
      do_reset();
      if_ce = 1; if_addr = 32'h0;
      dm_ce = 1; dm_we = 1; dm_sel = 4'b0011; dm_addr = 32'h200; dm_data = 32'h55AA55AA;
      @(negedge clk);
      chk("sim_if_stall_c0", 32'(ifst[0]), 32'd1);
      next_cycle();
      bus_ack = 1; bus_dat_i = 32'h12345678;
      @(negedge clk);
      chk("sim_store_we", 32'(we[0]), 32'd1);
      chk("sim_store_sel", 32'(sel[0]), 32'h3);
      chk("sim_store_dat", dato[0], 32'h55AA55AA);
      next_cycle();
      bus_ack = 0;
      @(negedge clk);
      chk("sim_dm_stall_done", 32'(dmst[0]), 32'd0);
      chk("sim_if_stall_c2", 32'(ifst[0]), 32'd1);
      next_cycle();
      dm_ce = 0; dm_we = 0;
      @(negedge clk);
      chk("sim_idle_gap_cyc", 32'(cyc[0]), 32'd0);
      chk("sim_if_stall_c3", 32'(ifst[0]), 32'd1);
      next_cycle();
      bus_ack = 1; bus_dat_i = 32'h00000013;
      @(negedge clk);
      chk("sim_fetch_cyc_c4", 32'(cyc[0]), 32'd1);
      chk("sim_fetch_sel", 32'(sel[0]), 32'hF);
      chk("sim_fetch_we", 32'(we[0]), 32'd0);
      next_cycle();
      bus_ack = 0;
      @(negedge clk);
      chk("sim_fetch_data", ifd[0], 32'h00000013);
      chk("sim_if_stall_done", 32'(ifst[0]), 32'd0);
      next_cycle();
      if_ce = 0;
      @(negedge clk);
      next_cycle();

      // Wait states: ack on the sixth strobe cycle
      do_reset();
      dm_ce = 1; dm_addr = 32'h300; dm_sel = 4'hF;
      stall_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         bus_ack = (c == 6);
         bus_dat_i = (c == 6) ? 32'hCAFEF00D : 32'h0;
         @(negedge clk);
         if (dmst[0]) stall_cnt++;
         if (c >= 1 && c <= 6) begin
            chk($sformatf("wait_cyc_c%0d", c), 32'(cyc[0]), 32'd1);
            chk($sformatf("wait_adr_c%0d", c), adr[0], 32'h300);
         end
         if (!dmst[0]) break;
         next_cycle();
      end
      chk("wait_stall_len", stall_cnt, 32'd7);
      chk("wait_data", dmd[0], 32'hCAFEF00D);
      next_cycle();
      dm_ce = 0; bus_ack = 0;
      @(negedge clk);
      next_cycle();

      // Flush during a load
      do_reset();
      dm_ce = 1; dm_addr = 32'h400; dm_sel = 4'hF;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      next_cycle();
      flush = 1;
      @(negedge clk);
      chk("flush_stall_c2", 32'(dmst[0]), 32'd1);
      next_cycle();
      flush = 0; dm_ce = 0;
      @(negedge clk);
      chk("flush_stall_follows_ce", 32'(dmst[0]), 32'd0);
      chk("flush_cyc_held", 32'(cyc[0]), 32'd1);
      next_cycle();
      bus_ack = 1; bus_dat_i = 32'h11111111;
      @(negedge clk);
      chk("flush_cyc_c4", 32'(cyc[0]), 32'd1);
      next_cycle();
      bus_ack = 0; dm_ce = 1;
      @(negedge clk);
      chk("flush_no_done", 32'(dmst[0]), 32'd1);
      chk("flush_data_kept", dmd[0], 32'h0);
      chk("flush_cyc_dropped", 32'(cyc[0]), 32'd0);
      next_cycle();
      dm_ce = 0;
      @(negedge clk);
      next_cycle();

      // Timeout on the 4-cycle instance, then reset the long-timeout instance mid-fetch
      do_reset();
      if_ce = 1; if_addr = 32'h500; bus_dat_i = 32'hFFFFFFFF;
      for (int c = 0; c < 7; c++) begin
         if (c == 6) if_ce = 0;
         @(negedge clk);
         chk($sformatf("to_cyc_c%0d", c), 32'(cyc[1]), 32'(c >= 1 && c <= 4));
         chk($sformatf("to_pulse_c%0d", c), 32'(to[1]), 32'(c == 5));
         if (c == 5) begin
            chk("to_if_stall_done", 32'(ifst[1]), 32'd0);
            chk("to_if_data", ifd[1], 32'h0);
         end
         next_cycle();
      end
      rst = 1;
      @(negedge clk);
      chk("rst_pre_cyc", 32'(cyc[0]), 32'd1);
      next_cycle();
      rst = 0; if_ce = 1; if_addr = 32'h700; bus_dat_i = 32'h0;
      @(negedge clk);
      chk("rst_cyc", 32'(cyc[0]), 32'd0);
      chk("rst_adr", adr[0], 32'h0);
      chk("rst_sel", 32'(sel[0]), 32'h0);
      chk("rst_timeout", 32'(to[0]), 32'd0);
      next_cycle();
      bus_ack = 1; bus_dat_i = 32'h0BADC0DE;
      @(negedge clk);
      chk("rst_refetch_adr", adr[0], 32'h700);
      next_cycle();
      bus_ack = 0;
      @(negedge clk);
      chk("rst_refetch_data", ifd[0], 32'h0BADC0DE);
      chk("rst_refetch_stall", 32'(ifst[0]), 32'd0);
      next_cycle();
      if_ce = 0;
      repeat (3) next_cycle();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-port memory bus arbiter between instruction fetch (IF) and the MEM stage data port. It serializes both requesters onto one Wishbone-classic master interface and returns read data through hold registers. It drives the per-port stall requests consumed by the pipeline control unit. It sits between the IF/MEM stages and the shared SRAM/peripheral bus.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: bus cycles without `bus_ack_i` before abort (1..255).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  pipeline flush (exception/eret); discards the in-flight result.
- `if_ce_i`  in  1  instruction fetch request.
- `if_addr_i`  in  32  fetch address.
- `if_data_o`  out  32  fetched instruction; valid in DONE_I.
- `if_stallreq_o`  out  1  stall request to the IF stage.
- `dm_ce_i`  in  1  data request (MEM `mem_ce_o`).
- `dm_we_i`  in  1  data write enable (already exception-gated).
- `dm_sel_i`  in  4  byte lanes; bit 3 = bits [31:24].
- `dm_addr_i`  in  32  data address.
- `dm_data_i`  in  32  store data.
- `dm_data_o`  out  32  load data; valid in DONE_D.
- `dm_stallreq_o`  out  1  stall request to the MEM stage.
- `bus_cyc_o`, `bus_stb_o`  out  1  Wishbone cycle and strobe; always equal.
- `bus_we_o`  out  1  bus write.
- `bus_sel_o`  out  4  bus byte select.
- `bus_adr_o`  out  32  bus address.
- `bus_dat_o`  out  32  bus write data.
- `bus_dat_i`  in  32  bus read data.
- `bus_ack_i`  in  1  bus acknowledge.
- `bus_timeout_o`  out  1  one-cycle pulse when a bus cycle is aborted.

## Operation

- States: IDLE, BUS_D, BUS_I, DONE_D, DONE_I.
- Side flags: `discard` (1 bit), `cnt` (8-bit timeout counter).
- IDLE with `flush`=0:
  - If `dm_ce_i`, go to BUS_D. Latch `dm_addr_i`/`dm_sel_i`/`dm_we_i`/`dm_data_i` into the bus registers.
  - Otherwise, if `if_ce_i`, go to BUS_I with addr = `if_addr_i`, sel = 4'b1111, we = 0.
  - Data has fixed priority: it is the older instruction.
- IDLE with `flush`=1: no grant; stay in IDLE.
- BUS_x: `bus_cyc_o`/`bus_stb_o` are held at 1, and the bus registers are held stable.
  - `cnt` increments each cycle and is cleared on entry.
  - On `bus_ack_i`=1: capture `bus_dat_i`, or 0 for writes, into that port's hold register. Drop cyc/stb next cycle. Go to DONE_x, or to IDLE if `discard`.
  - On `cnt` == TIMEOUT_CYCLES-1 with no ack: hold register = 0. Pulse `bus_timeout_o` on the following cycle. Drop cyc/stb. Go to DONE_x, or to IDLE if `discard`.
  - On `flush` in BUS_x: set `discard`. The bus cycle is never aborted early by flush. `discard` clears on leaving BUS_x.
- DONE_x: lasts exactly one cycle, then IDLE. `flush` in DONE_x also goes to IDLE.
- Stall requests (combinational from state and inputs):
  - IDLE: `dm_stallreq_o` = `dm_ce_i`; `if_stallreq_o` = `if_ce_i`.
  - BUS_D with `discard`=0: `dm_stallreq_o`=1. BUS_I with `discard`=0: `if_stallreq_o`=1.
  - DONE_D: `dm_stallreq_o`=0. DONE_I: `if_stallreq_o`=0.
  - Any other port/state combination: stall = that port's `ce_i`. A request waiting behind another transfer stays stalled.
- `if_data_o`/`dm_data_o` always drive their hold registers. Hold registers update only on capture.
- `bus_we_o` is forced 0 for fetches. A write with `dm_sel_i`=0 is still issued as a bus cycle.

## Timing

- Reset (`rst`=1 at an edge): state IDLE, `discard`=0, `cnt`=0.
- Outputs after reset: `bus_cyc_o`=`bus_stb_o`=`bus_we_o`=0, `bus_sel_o`=0, `bus_adr_o`=0, `bus_dat_o`=0, hold registers 0, `bus_timeout_o`=0.
- Reset mid-transfer drops cyc/stb on the next edge with no DONE cycle.
- Bus outputs are registered. Request seen in IDLE at cycle 0 → cyc/stb high from cycle 1.
- With ack in cycle 1: DONE in cycle 2, stall low in cycle 2, IDLE in cycle 3. Minimum 2 stalled cycles per access.
- Ack after n wait cycles adds n stall cycles.
- Back-to-back: a pending request is granted in the IDLE cycle after DONE. There is no bus idle gap beyond that IDLE cycle.
- Simultaneous `dm_ce_i` and `if_ce_i`: data is served first, fetch second.
- `bus_ack_i` outside BUS_x is ignored.

## Test plan

- **Single load.** `dm_ce_i`=1, addr 0x100, sel 1111, slave acks on the first strobe cycle with 0xDEADBEEF. Required: `dm_stallreq_o`=1 for cycles 0–1; DONE_D in cycle 2 with `dm_data_o`=0xDEADBEEF and stall 0; `bus_adr_o`=0x100.
- **Simultaneous requests.** `if_ce_i` and `dm_ce_i` at cycle 0 (fetch 0x0, store 0x55AA55AA to 0x200, sel 0011). Required: the store is issued first with `bus_we_o`=1 and `bus_sel_o`=0011; the fetch is issued from cycle 4; `if_stallreq_o` stays high until DONE_I.
- **Wait states.** Ack delayed 5 cycles. Required: cyc/stb and address stable for all 6 strobe cycles; stall duration is 7 cycles.
- **Flush during transfer.** `flush` in the second BUS_D cycle, ack 2 cycles later. Required: the bus cycle completes; no DONE_D; `dm_data_o` unchanged; `dm_stallreq_o` follows `dm_ce_i` after the flush.
- **Timeout.** `TIMEOUT_CYCLES`=4, no ack. Required: cyc/stb drop after 4 cycles; `bus_timeout_o` pulses for 1 cycle; DONE with data 0.
- **Reset mid-cycle.** `rst` asserted in BUS_I. Required: all outputs 0 and state IDLE on the next edge; a later fetch works normally.
